universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 64 ++++++
 tb/tb_universal_shift_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, parallel load, shift and rotate in both directions, clear and set.
// qbar and the serial-out taps are combinational views of q. The changed flag is registered.
module universal_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             changed
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_SET  = 3'b111;

  logic [WIDTH-1:0] q_next;

  // en=0 collapses every mode to hold, so changed falls out of one comparison
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
        MODE_SHR:  q_next = {sin_msb, q[WIDTH-1:1]};
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        MODE_CLR:  q_next = '0;
        MODE_SET:  q_next = '1;
        default:   q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= (q_next != q);
    end
  end

  assign qbar     = ~q;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=4, RESET_VAL=0): directed scenarios then a random stream
// compared against an arithmetic reference model of the register.
module tb_universal_shift_reg;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, en, sin_lsb, sin_msb;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, qbar;
  logic         sout_msb, sout_lsb, changed;

  int ncmp = 0;
  int nerr = 0;

  int unsigned mq;
  int unsigned mch;

  universal_shift_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb),
    .q(q), .qbar(qbar), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: next register value as plain integer arithmetic on a 4-bit number
  function automatic int unsigned model_next(input int unsigned cur, input bit e, input int unsigned m,
                                             input int unsigned dv, input int unsigned sl, input int unsigned sm);
    if (!e) return cur;
    case (m)
      0: return cur;
      1: return dv & MASK;
      2: return ((cur * 2) + sl) & MASK;
      3: return (cur / 2) + sm * (1 << (W - 1));
      4: return ((cur * 2) + (cur / (1 << (W - 1)))) & MASK;
      5: return (cur / 2) + (cur % 2) * (1 << (W - 1));
      6: return 0;
      default: return MASK;
    endcase
  endfunction

  // Apply inputs, clock once, update model, sample #1 after the edge
  task automatic step(input bit r, input bit e, input int unsigned m, input int unsigned dv,
                      input bit sl, input bit sm);
    int unsigned nq;
    reset = r; en = e; mode = m[2:0]; d = dv[W-1:0]; sin_lsb = sl; sin_msb = sm;
    if (r) begin
      nq = 0;
      mch = 0;
    end else begin
      nq = model_next(mq, e, m, dv, sl, sm);
      mch = (nq != mq) ? 1 : 0;
    end
    mq = nq;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".q"}, q, mq);
    chk({tag, ".qbar"}, qbar, (~mq) & MASK);
    chk({tag, ".changed"}, changed, mch);
  endtask

  int unsigned shl_q[4]   = '{4'h6, 4'hC, 4'h8, 4'h0};
  int unsigned shl_out[4] = '{1, 0, 1, 1};
  int unsigned ror_q[4]   = '{4'hD, 4'hE, 4'h7, 4'hB};

  initial begin
    mq = 0; mch = 0;
    reset = 1'b1; en = 1'b0; mode = 3'b000; d = '0; sin_lsb = 1'b0; sin_msb = 1'b0;
    #2;

    // Reset has priority over en/mode
    step(1, 1, 7, 0, 0, 0);
    chk("reset.q", q, 4'h0);
    chk("reset.qbar", qbar, 4'hF);
    chk("reset.changed", changed, 0);

    step(0, 1, 1, 4'hB, 0, 0);
    chk("load.q", q, 4'hB);
    chk("load.qbar", qbar, 4'h4);
    chk("load.changed", changed, 1);

    // Shift left with zero fill; the outgoing msb is visible before each edge
    for (int i = 0; i < 4; i++) begin
      reset = 0; en = 1; mode = 3'b010; sin_lsb = 0; #1;
      chk($sformatf("shl.sout_msb%0d", i), sout_msb, shl_out[i]);
      step(0, 1, 2, 0, 0, 0);
      chk($sformatf("shl.q%0d", i), q, shl_q[i]);
    end

    step(0, 1, 1, 4'hB, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5, 0, 1, 1);
      chk($sformatf("ror.q%0d", i), q, ror_q[i]);
      chk($sformatf("ror.changed%0d", i), changed, 1);
    end
    step(0, 1, 1, 4'hF, 0, 0);
    step(0, 1, 5, 0, 0, 0);
    chk("ror_ones.q", q, 4'hF);
    chk("ror_ones.changed", changed, 0);

    step(0, 1, 1, 4'hF, 0, 0);
    chk("load_same.changed", changed, 0);

    // en=0 freezes q under every mode
    step(0, 1, 1, 4'h5, 0, 0);
    step(0, 0, 6, 0, 0, 0);
    chk("hold_clr.q", q, 4'h5);
    chk("hold_clr.changed", changed, 0);
    step(0, 0, 7, 0, 1, 1);
    chk("hold_set.q", q, 4'h5);
    chk("hold_set.changed", changed, 0);
    step(0, 0, 1, 4'hF, 0, 0);
    chk("hold_load.q", q, 4'h5);
    chk("hold_load.changed", changed, 0);

    // Reset mid-sequence, then the first enabled edge operates on the reset value
    step(0, 1, 1, 4'hA, 0, 0);
    step(0, 1, 3, 0, 0, 1);
    chk("shr.q", q, 4'hD);
    chk("shr.sout_lsb", sout_lsb, 1);
    step(1, 1, 7, 0, 0, 0);
    chk("midreset.q", q, 4'h0);
    chk("midreset.changed", changed, 0);
    step(0, 1, 2, 0, 1, 0);
    chk("post_reset_shl.q", q, 4'h1);

    // Serial inputs ignored by rotate
    step(0, 1, 1, 4'h0, 0, 0);
    step(0, 1, 4, 0, 1, 1);
    chk("rol_zero.q", q, 4'h0);
    chk("rol_zero.changed", changed, 0);

    for (int i = 0; i < 1000; i++) begin
      bit r;
      r = ($urandom_range(0, 49) == 0);
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, MASK),
           $urandom_range(0, 1), $urandom_range(0, 1));
      chk_state("rnd");
      chk("rnd.sout_msb", sout_msb, (mq >> (W - 1)) & 1);
      chk("rnd.sout_lsb", sout_lsb, mq & 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
